// File: rtl/ax_branch_approx_decider_pkg.sv
// Shared approximate-execution configuration: core-wide defaults, level type and LFSR polynomial.
// Imported by the decider, its LFSR and any other approximate unit.
package ax_branch_approx_decider_pkg;

   localparam int unsigned CONF_FETCH_WIDTH     = 4;
   localparam int unsigned CONF_AX_LEVEL_WIDTH  = 5;
   localparam int unsigned CONF_LFSR_WIDTH      = 32;
   localparam logic [31:0] CONF_LFSR_SEED       = 32'h0000_1010;

   // Maximal-length right-shift Galois taps.
   localparam logic [31:0] AX_LFSR_MASK         = 32'h8020_0003;

   typedef logic [CONF_AX_LEVEL_WIDTH-1:0] AxLevelPath;

endpackage

// File: rtl/ax_branch_approx_decider_if.sv
// Front-end side of the approximate branch decider: requests, level/counter control and decisions.
interface ax_branch_approx_decider_if #(
   parameter int unsigned FETCH_WIDTH    = 4,
   parameter int unsigned AX_LEVEL_WIDTH = 5,
   parameter int unsigned COUNT_WIDTH    = 32
) ();

   logic                      stall;
   logic [FETCH_WIDTH-1:0]    req;
   logic                      levelWe;
   logic [AX_LEVEL_WIDTH-1:0] levelIn;
   logic                      countClear;
   logic [FETCH_WIDTH-1:0]    decValid;
   logic [FETCH_WIDTH-1:0]    decApprox;
   logic [AX_LEVEL_WIDTH-1:0] level;
   logic [COUNT_WIDTH-1:0]    approxCount;

   modport master (
      output stall, req, levelWe, levelIn, countClear,
      input  decValid, decApprox, level, approxCount
   );

   modport slave (
      input  stall, req, levelWe, levelIn, countClear,
      output decValid, decApprox, level, approxCount
   );

endinterface

// File: rtl/ax_lfsr.sv
// Seeded right-shift Galois LFSR that steps only when asked; reusable by any approximate unit.
module ax_lfsr
   import ax_branch_approx_decider_pkg::*;
#(
   parameter int unsigned       WIDTH = CONF_LFSR_WIDTH,
   parameter logic [WIDTH-1:0]  SEED  = WIDTH'(CONF_LFSR_SEED),
   parameter logic [WIDTH-1:0]  MASK  = WIDTH'(AX_LFSR_MASK)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             advance,
   output logic [WIDTH-1:0] value
);

   logic [WIDTH-1:0] state_q;
   logic [WIDTH-1:0] state_d;

   // An all-zero state is a fixed point, so the seed must be nonzero.
   if (SEED == '0) begin : gen_seed_check
      $error("ax_lfsr: SEED must be nonzero");
   end

   always_comb begin
      state_d = state_q;
      if (advance) begin
         state_d = state_q[0] ? ((state_q >> 1) ^ MASK) : (state_q >> 1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= SEED;
      end else begin
         state_q <= state_d;
      end
   end

   assign value = state_q;

endmodule

// File: rtl/ax_branch_approx_decider.sv
// Per-lane stochastic approve/reject for approximable branches, with a saturating approval count.
module ax_branch_approx_decider
   import ax_branch_approx_decider_pkg::*;
#(
   parameter int unsigned            FETCH_WIDTH    = CONF_FETCH_WIDTH,
   parameter int unsigned            AX_LEVEL_WIDTH = CONF_AX_LEVEL_WIDTH,
   parameter int unsigned            LFSR_WIDTH     = CONF_LFSR_WIDTH,
   parameter logic [LFSR_WIDTH-1:0]  LFSR_SEED      = LFSR_WIDTH'(CONF_LFSR_SEED),
   parameter int unsigned            COUNT_WIDTH    = 32
) (
   input logic                        clk,
   input logic                        rst,
   ax_branch_approx_decider_if.slave  bus
);

   localparam int unsigned RND_BITS = FETCH_WIDTH * AX_LEVEL_WIDTH;

   if (LFSR_WIDTH < RND_BITS) begin : gen_width_check
      $error("ax_branch_approx_decider: LFSR_WIDTH must cover FETCH_WIDTH*AX_LEVEL_WIDTH");
   end

   logic [LFSR_WIDTH-1:0]     lfsr_value;
   logic                      accept;
   logic                      advance;
   logic [FETCH_WIDTH-1:0]    approve;
   logic [FETCH_WIDTH-1:0]    dec_valid_q;
   logic [FETCH_WIDTH-1:0]    dec_approx_q;
   logic [AX_LEVEL_WIDTH-1:0] level_q;
   logic [COUNT_WIDTH-1:0]    count_q;
   logic [COUNT_WIDTH-1:0]    count_d;
   logic [COUNT_WIDTH-1:0]    count_base;
   logic [COUNT_WIDTH:0]      incr;
   logic [COUNT_WIDTH:0]      sum;

   assign accept  = !bus.stall;
   // The sequence only moves when a decision actually consumes random bits.
   assign advance = accept && (|bus.req);

   ax_lfsr #(
      .WIDTH (LFSR_WIDTH),
      .SEED  (LFSR_SEED),
      .MASK  (LFSR_WIDTH'(AX_LFSR_MASK))
   ) u_lfsr (
      .clk     (clk),
      .rst     (rst),
      .advance (advance),
      .value   (lfsr_value)
   );

   if (LFSR_WIDTH > RND_BITS) begin : gen_spare_bits
      logic unused_lfsr_bits;
      assign unused_lfsr_bits = ^lfsr_value[LFSR_WIDTH-1:RND_BITS];
   end

   always_comb begin
      approve = '0;
      for (int unsigned i = 0; i < FETCH_WIDTH; i++) begin
         approve[i] = bus.req[i] &&
                      (lfsr_value[i*AX_LEVEL_WIDTH +: AX_LEVEL_WIDTH] < level_q);
      end
   end

   // Clear wins over the old value but still lets this cycle's approvals land.
   always_comb begin
      incr = '0;
      for (int unsigned i = 0; i < FETCH_WIDTH; i++) begin
         incr = incr + (COUNT_WIDTH+1)'(approve[i]);
      end
      count_base = bus.countClear ? '0 : count_q;
      sum        = {1'b0, count_base} + incr;
      count_d    = count_base;
      if (accept) begin
         count_d = sum[COUNT_WIDTH] ? '1 : sum[COUNT_WIDTH-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         dec_valid_q  <= '0;
         dec_approx_q <= '0;
         level_q      <= '0;
         count_q      <= '0;
      end else begin
         if (bus.levelWe) begin
            level_q <= bus.levelIn;
         end
         if (accept) begin
            dec_valid_q  <= bus.req;
            dec_approx_q <= approve;
         end else begin
            dec_valid_q  <= '0;
            dec_approx_q <= '0;
         end
         count_q <= count_d;
      end
   end

   assign bus.decValid    = dec_valid_q;
   assign bus.decApprox   = dec_approx_q;
   assign bus.level       = level_q;
   assign bus.approxCount = count_q;

endmodule

// File: tb/tb_ax_branch_approx_decider.sv
// Bench for ax_branch_approx_decider: fixed vector table, directed corner sequences, random run.
module tb_ax_branch_approx_decider;
   import ax_branch_approx_decider_pkg::*;

   localparam int unsigned FW   = 4;
   localparam int unsigned LW   = 5;
   localparam int unsigned CW   = 4;
   localparam int unsigned CMAX = (1 << CW) - 1;
   localparam logic [31:0] SEED = 32'h0000_1010;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   ax_branch_approx_decider_if #(
      .FETCH_WIDTH    (FW),
      .AX_LEVEL_WIDTH (LW),
      .COUNT_WIDTH    (CW)
   ) bus ();

   ax_branch_approx_decider #(
      .FETCH_WIDTH    (FW),
      .AX_LEVEL_WIDTH (LW),
      .LFSR_WIDTH     (32),
      .LFSR_SEED      (SEED),
      .COUNT_WIDTH    (CW)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   int unsigned total = 0;
   int unsigned bad   = 0;

   // Reference model state
   logic [31:0]   m_lfsr;
   int unsigned   m_level;
   int unsigned   m_count;
   logic [FW-1:0] m_valid;
   logic [FW-1:0] m_approx;

   typedef struct {
      logic        r;
      logic        s;
      logic [3:0]  q;
      logic        we;
      logic [4:0]  li;
      logic        clr;
      logic [3:0]  ev;
      logic [3:0]  ea;
      int unsigned ec;
      logic [31:0] el;
   } vec_t;

   vec_t tbl [19];

   function automatic logic [31:0] lfsr_next(input logic [31:0] v);
      return v[0] ? ((v >> 1) ^ AX_LFSR_MASK) : (v >> 1);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_step(input logic r, input logic s, input logic [FW-1:0] q,
                             input logic we, input AxLevelPath li, input logic clr);
      logic [FW-1:0] a;
      a = '0;
      for (int i = 0; i < FW; i++) begin
         if (q[i] && (((m_lfsr >> (LW * i)) & 32'h1f) < m_level)) a[i] = 1'b1;
      end
      if (r) begin
         m_lfsr = SEED; m_level = 0; m_count = 0; m_valid = '0; m_approx = '0;
      end else begin
         if (clr) m_count = 0;
         if (!s) begin
            m_valid  = q;
            m_approx = a;
            m_count  = m_count + $countones(a);
            if (m_count > CMAX) m_count = CMAX;
            if (q != '0) m_lfsr = lfsr_next(m_lfsr);
         end else begin
            m_valid  = '0;
            m_approx = '0;
         end
         if (we) m_level = li;
      end
   endtask

   task automatic cycle(input logic r, input logic s, input logic [FW-1:0] q,
                        input logic we, input AxLevelPath li, input logic clr);
      rst            = r;
      bus.stall      = s;
      bus.req        = q;
      bus.levelWe    = we;
      bus.levelIn    = li;
      bus.countClear = clr;
      model_step(r, s, q, we, li, clr);
      @(posedge clk);
      #1;
      check("decValid", 32'(bus.decValid), 32'(m_valid));
      check("decApprox", 32'(bus.decApprox), 32'(m_approx));
      check("level", 32'(bus.level), m_level);
      check("approxCount", 32'(bus.approxCount), m_count);
      check("lfsr", dut.u_lfsr.value, m_lfsr);
   endtask

   initial begin
      //           r     s     q     we    li     clr   ev    ea    ec  el
      tbl[0]  = '{1'b1, 1'b0, 4'hf, 1'b0, 5'd0,  1'b0, 4'h0, 4'h0, 0,  32'h0000_1010};
      tbl[1]  = '{1'b0, 1'b0, 4'h0, 1'b1, 5'd17, 1'b0, 4'h0, 4'h0, 0,  32'h0000_1010};
      tbl[2]  = '{1'b0, 1'b0, 4'hf, 1'b0, 5'd0,  1'b0, 4'hf, 4'hf, 4,  32'h0000_0808};
      tbl[3]  = '{1'b0, 1'b0, 4'hf, 1'b1, 5'd1,  1'b0, 4'hf, 4'hf, 8,  32'h0000_0404};
      tbl[4]  = '{1'b0, 1'b0, 4'hf, 1'b0, 5'd0,  1'b0, 4'hf, 4'ha, 10, 32'h0000_0202};
      tbl[5]  = '{1'b0, 1'b1, 4'hf, 1'b0, 5'd0,  1'b0, 4'h0, 4'h0, 10, 32'h0000_0202};
      tbl[6]  = '{1'b0, 1'b0, 4'h5, 1'b0, 5'd0,  1'b0, 4'h5, 4'h4, 11, 32'h0000_0101};
      tbl[7]  = '{1'b0, 1'b0, 4'hf, 1'b0, 5'd0,  1'b1, 4'hf, 4'hc, 2,  32'h8020_0083};
      tbl[8]  = '{1'b0, 1'b0, 4'h0, 1'b1, 5'd31, 1'b0, 4'h0, 4'h0, 2,  32'h8020_0083};
      tbl[9]  = '{1'b0, 1'b0, 4'hf, 1'b0, 5'd0,  1'b0, 4'hf, 4'hf, 6,  32'hc030_0042};
      tbl[10] = '{1'b1, 1'b0, 4'hf, 1'b0, 5'd0,  1'b0, 4'h0, 4'h0, 0,  32'h0000_1010};
      tbl[11] = '{1'b0, 1'b0, 4'h0, 1'b1, 5'd17, 1'b0, 4'h0, 4'h0, 0,  32'h0000_1010};
      tbl[12] = '{1'b0, 1'b0, 4'hf, 1'b0, 5'd0,  1'b0, 4'hf, 4'hf, 4,  32'h0000_0808};
      tbl[13] = '{1'b0, 1'b0, 4'hf, 1'b0, 5'd0,  1'b0, 4'hf, 4'hf, 8,  32'h0000_0404};
      tbl[14] = '{1'b0, 1'b0, 4'hf, 1'b0, 5'd0,  1'b0, 4'hf, 4'hf, 12, 32'h0000_0202};
      tbl[15] = '{1'b0, 1'b0, 4'h3, 1'b0, 5'd0,  1'b0, 4'h3, 4'h3, 14, 32'h0000_0101};
      tbl[16] = '{1'b0, 1'b0, 4'hf, 1'b0, 5'd0,  1'b0, 4'hf, 4'hf, 15, 32'h8020_0083};
      tbl[17] = '{1'b0, 1'b0, 4'hf, 1'b0, 5'd0,  1'b0, 4'hf, 4'hf, 15, 32'hc030_0042};
      tbl[18] = '{1'b0, 1'b0, 4'h0, 1'b0, 5'd0,  1'b1, 4'h0, 4'h0, 0,  32'hc030_0042};

      for (int i = 0; i < 19; i++) begin
         cycle(tbl[i].r, tbl[i].s, tbl[i].q, tbl[i].we, tbl[i].li, tbl[i].clr);
         check($sformatf("tbl%0d.decValid", i), 32'(bus.decValid), 32'(tbl[i].ev));
         check($sformatf("tbl%0d.decApprox", i), 32'(bus.decApprox), 32'(tbl[i].ea));
         check($sformatf("tbl%0d.count", i), 32'(bus.approxCount), tbl[i].ec);
         check($sformatf("tbl%0d.lfsr", i), dut.u_lfsr.value, tbl[i].el);
      end

      // Level 0 never approves.
      cycle(1'b1, 1'b0, 4'h0, 1'b0, 5'd0, 1'b0);
      for (int i = 0; i < 10; i++) begin
         cycle(1'b0, 1'b0, 4'hf, 1'b0, 5'd0, 1'b0);
         check("lvl0.decValid", 32'(bus.decValid), 32'hf);
         check("lvl0.decApprox", 32'(bus.decApprox), 32'h0);
         check("lvl0.count", 32'(bus.approxCount), 32'h0);
      end

      // Stall freezes the sequence; the first decision after release is the unstalled one.
      cycle(1'b1, 1'b0, 4'h0, 1'b0, 5'd0, 1'b0);
      cycle(1'b0, 1'b0, 4'h0, 1'b1, 5'd17, 1'b0);
      for (int i = 0; i < 3; i++) begin
         cycle(1'b0, 1'b1, 4'hf, 1'b0, 5'd0, 1'b0);
         check("stall.decValid", 32'(bus.decValid), 32'h0);
         check("stall.lfsr", dut.u_lfsr.value, SEED);
      end
      cycle(1'b0, 1'b0, 4'hf, 1'b0, 5'd0, 1'b0);
      check("release.decApprox", 32'(bus.decApprox), 32'hf);
      check("release.count", 32'(bus.approxCount), 32'd4);
      check("release.lfsr", dut.u_lfsr.value, 32'h0000_0808);

      // Level write during stall is still honored.
      cycle(1'b0, 1'b1, 4'h0, 1'b1, 5'd9, 1'b0);
      check("stallwe.level", 32'(bus.level), 32'd9);

      // Random traffic against the model.
      for (int i = 0; i < 600; i++) begin
         cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) == 0), FW'($urandom),
               ($urandom_range(0, 7) == 0), AxLevelPath'($urandom),
               ($urandom_range(0, 19) == 0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ax_branch_approx_decider.md
# ax_branch_approx_decider

Per-cycle stochastic decision unit for the approximate-execution front end. Each fetch lane flagged as an approximable branch receives an approve/reject decision with probability level/2^AX_LEVEL_WIDTH. Randomness comes from a seeded Galois LFSR. The block sits between fetch-stage branch identification and the branch predictor/AXBTB update path, and its outputs steer which lanes take the approximate path. It also keeps a saturating count of approved decisions for performance monitoring.

## Interface
Parameters:
- FETCH_WIDTH, 4, number of request lanes
- AX_LEVEL_WIDTH, 5, width of approximation level and of each lane's random slice
- LFSR_WIDTH, 32, LFSR width; must be >= FETCH_WIDTH*AX_LEVEL_WIDTH (elaboration-time assertion)
- LFSR_SEED, 32'h1010, LFSR reset value; must be nonzero
- COUNT_WIDTH, 32, approval counter width

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- stall  in  1  front-end stall; freezes the block
- req  in  FETCH_WIDTH  per-lane decision request
- levelWe  in  1  level write enable
- levelIn  in  AX_LEVEL_WIDTH  new approximation level
- countClear  in  1  clear approval counter
- decValid  out  FETCH_WIDTH  registered: lane had a request last accepted cycle
- decApprox  out  FETCH_WIDTH  registered: lane approved for approximation
- level  out  AX_LEVEL_WIDTH  current level register
- approxCount  out  COUNT_WIDTH  saturating approved-decision count

## Operation
- State: lfsr (LFSR_WIDTH), levelReg, decValid/decApprox registers, count.
- Lane i random value: rnd_i = lfsr[i*AX_LEVEL_WIDTH +: AX_LEVEL_WIDTH], unsigned.
- Approve: approve_i = req[i] && (rnd_i < levelReg).
  - Level 0 never approves.
  - Level 2^AX_LEVEL_WIDTH-1 approves with probability 31/32.
- A cycle is accepted when !stall.
  - Accepted cycle: decValid <= req, decApprox <= approve.
  - Stalled cycle: decValid <= 0, decApprox <= 0.
- LFSR update (right-shift Galois, mask 32'h8020_0003): next = lfsr[0] ? (lfsr>>1) ^ mask : lfsr>>1.
  - Advances only on an accepted cycle with |req.
  - Holds otherwise.
- Level: on levelWe, levelReg <= levelIn. levelWe is honored even during stall.
- Counter: on an accepted cycle, count increments by popcount(approve).
  - Saturates at all-ones; no wrap.
  - Precedence: rst > countClear > increment. With countClear and increments in the same cycle, count becomes the increment amount.

## Timing
- Reset values: lfsr=LFSR_SEED, levelReg=0, decValid=0, decApprox=0, approxCount=0.
- Latency: request in cycle N produces decValid/decApprox in cycle N+1. The decision uses the lfsr and levelReg values of cycle N.
- A level written in cycle N affects requests from cycle N+1. A request concurrent with the write uses the old level.
- Outputs are valid for exactly one cycle. There is no backpressure.
- The LFSR never reaches zero, because the seed is nonzero and the polynomial is maximal-length.
- Reset mid-operation discards pending decisions and restarts the random sequence from the seed. This makes runs deterministic.
- The counter add uses a COUNT_WIDTH+1-bit sum. Overflow clamps to all-ones.

## Structure
- Add to the shared approx package:
  - AxLevelPath typedef (logic [AX_LEVEL_WIDTH-1:0]).
  - LFSR mask constant 32'h8020_0003.
  - Defaults tied to the core's approx config (CONF_AX_LEVEL_WIDTH, CONF_LFSR_WIDTH, CONF_LFSR_SEED, CONF_FETCH_WIDTH).
- Sub-module ax_lfsr: parameters WIDTH, SEED, MASK; ports clk, rst, advance, value. It is reusable by other approximate units.
- Decision compare, popcount and saturating counter live in the top module.

## Test plan
- Reset, level 0, req=4'b1111 for 10 cycles → decValid=1111 each following cycle, decApprox=0000, approxCount=0.
- Reset, levelIn=17 written; next cycle req=1111 → LFSR=0x1010, rnd={0,4,0,16} (lanes 3..0), decApprox=1111, count=4, LFSR becomes 0x0808.
- Reset, level=1, req=1111 → decApprox=1010 (lanes 1,3 have rnd 0), count=2.
- stall=1 with req=1111 for 3 cycles → decValid=0, LFSR stays 0x1010; after release, the first decision matches the unstalled expectation.
- Preload count near max (COUNT_WIDTH=4, count=14), approve 4 lanes → count=15 (saturated). countClear with 2 approvals the same cycle → count=2.
- levelWe (level 31) in the same cycle as req → that decision uses the old level. Reset asserted mid-run → all outputs 0 and LFSR=0x1010 the next cycle.
